// File: rtl/mem_arbiter.sv
// Transaction-level round-robin arbiter sharing one memory port between the I-cache (port 0) and D-cache (port 1).
// Define MEM_ARB_PERF_EN to add per-port grant and wait performance counters.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_cs_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cs_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,

    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,

`ifdef MEM_ARB_PERF_EN
    output logic [CNT_WIDTH-1:0]  perf_grant0_o,
    output logic [CNT_WIDTH-1:0]  perf_grant1_o,
    output logic [CNT_WIDTH-1:0]  perf_wait0_o,
    output logic [CNT_WIDTH-1:0]  perf_wait1_o,
`endif

    output logic [1:0]            arb_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    typedef struct packed {
        state_t st;
        logic   last;
    } pick_t;

    state_t state;
    logic   last;
    pick_t  nxt;

    // Ties go to the port that was not granted most recently.
    function automatic pick_t arbitrate(input logic cs0, input logic cs1, input logic lst);
        pick_t p;
        p.st   = S_IDLE;
        p.last = lst;
        if (cs0 && (!cs1 || lst)) begin
            p.st   = S_OWN0;
            p.last = 1'b0;
        end else if (cs1) begin
            p.st   = S_OWN1;
            p.last = 1'b1;
        end
        return p;
    endfunction

    // The owner's release edge re-arbitrates immediately, so a waiting port gets no idle bubble.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves nxt unassigned and infers a latch.
        nxt.st   = state;
        nxt.last = last;
        case (state)
            S_IDLE: nxt = arbitrate(m0_cs_i, m1_cs_i, last);
            S_OWN0: if (!m0_cs_i) nxt = arbitrate(m0_cs_i, m1_cs_i, last);
            S_OWN1: if (!m1_cs_i) nxt = arbitrate(m0_cs_i, m1_cs_i, last);
            default: nxt.st = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
            last  <= 1'b1;
        end else begin
            state <= nxt.st;
            last  <= nxt.last;
        end
    end

    assign arb_state = state;

    // Ownership routes the whole protocol through combinationally; the non-owner sees zeros.
    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        m0_ack_o   = 1'b0;
        m0_data_o  = '0;
        m1_ack_o   = 1'b0;
        m1_data_o  = '0;
        case (state)
            S_OWN0: begin
                mem_cs_o   = m0_cs_i;
                mem_we_o   = m0_we_i;
                mem_addr_o = m0_addr_i;
                mem_data_o = m0_data_i;
                m0_ack_o   = mem_ack_i;
                m0_data_o  = mem_data_i;
            end
            S_OWN1: begin
                mem_cs_o   = m1_cs_i;
                mem_we_o   = m1_we_i;
                mem_addr_o = m1_addr_i;
                mem_data_o = m1_data_i;
                m1_ack_o   = mem_ack_i;
                m1_data_o  = mem_data_i;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] grant0_q, grant1_q, wait0_q, wait1_q;

    // A wait cycle is one where a port requests while the other port owns memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_q <= '0;
            grant1_q <= '0;
            wait0_q  <= '0;
            wait1_q  <= '0;
        end else begin
            if (nxt.st == S_OWN0 && state != S_OWN0) grant0_q <= grant0_q + CNT_ONE;
            if (nxt.st == S_OWN1 && state != S_OWN1) grant1_q <= grant1_q + CNT_ONE;
            if (m0_cs_i && state == S_OWN1)          wait0_q  <= wait0_q + CNT_ONE;
            if (m1_cs_i && state == S_OWN0)          wait1_q  <= wait1_q + CNT_ONE;
        end
    end

    assign perf_grant0_o = grant0_q;
    assign perf_grant1_o = grant1_q;
    assign perf_wait0_o  = wait0_q;
    assign perf_wait1_o  = wait1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single grant, tie alternation, held bursts, spurious ack, mid-transaction reset.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cs_i, m0_we_i, m1_cs_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          m0_ack_o, m1_ack_o;
    logic          mem_cs_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_ack_i;
    logic [1:0]    arb_state;
`ifdef MEM_ARB_PERF_EN
    logic [CW-1:0] perf_grant0_o, perf_grant1_o, perf_wait0_o, perf_wait1_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .m0_cs_i(m0_cs_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_cs_i(m1_cs_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
`ifdef MEM_ARB_PERF_EN
        .perf_grant0_o(perf_grant0_o), .perf_grant1_o(perf_grant1_o),
        .perf_wait0_o(perf_wait0_o), .perf_wait1_o(perf_wait1_o),
`endif
        .arb_state(arb_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_cs_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_cs_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", arb_state); end
        n_vec++; if (mem_cs_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs_o); end
        n_vec++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_acks: got %b%b want 00", m0_ack_o, m1_ack_o); end
    endtask

    task automatic test_single;
        m0_cs_i = 1'b1; m0_addr_i = 32'h100; mem_ack_i = 1'b1; mem_data_i = 32'h0000_0011;
        #1;
        n_vec++; if (mem_cs_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle: cs=%b ack=%b want 0 0", mem_cs_o, m0_ack_o); end
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL single_state: got %0d want 1", arb_state); end
        n_vec++; if (mem_addr_o !== 32'h100 || mem_cs_o !== 1'b1) begin n_err++; $display("FAIL single_addr: got %h cs=%b want 100 cs=1", mem_addr_o, mem_cs_o); end
        n_vec++; if (m0_ack_o !== 1'b1 || m0_data_o !== 32'h11 || m1_ack_o !== 1'b0) begin n_err++; $display("FAIL single_ack: got ack0=%b d0=%h ack1=%b want 1 11 0", m0_ack_o, m0_data_o, m1_ack_o); end
        mem_ack_i = 1'b0;
        #1;
        n_vec++; if (m0_ack_o !== 1'b0) begin n_err++; $display("FAIL single_ack_follow: got %b want 0", m0_ack_o); end
        tick();
        m0_cs_i = 1'b0;
        tick();
        n_vec++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL single_release: got %0d want 0", arb_state); end
    endtask

    task automatic test_tie;
        do_reset();
        m0_cs_i = 1'b1; m1_cs_i = 1'b1; mem_ack_i = 1'b1;
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL tie_first: got %0d want 1", arb_state); end
        n_vec++; if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b1) begin n_err++; $display("FAIL tie_nonowner_ack: got ack0=%b ack1=%b want 1 0", m0_ack_o, m1_ack_o); end
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL tie_hold: got %0d want 1", arb_state); end
        m0_cs_i = 1'b0;
        tick();
        n_vec++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL tie_handoff: got %0d want 2", arb_state); end
        m0_cs_i = 1'b1;
        tick();
        n_vec++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL tie_no_preempt: got %0d want 2", arb_state); end
        m0_cs_i = 1'b0; m1_cs_i = 1'b0;
        tick();
        m0_cs_i = 1'b1; m1_cs_i = 1'b1;
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL tie_alternate: got %0d want 1", arb_state); end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back;
        m1_cs_i = 1'b1;
        tick();
        n_vec++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL b2b_grant1: got %0d want 2", arb_state); end
        for (int i = 0; i < 8; i++) begin
            m1_we_i = (i < 4); m1_addr_i = 32'h200 + i; m1_data_i = 32'hA0 + i;
            mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
            if (i == 2) m0_cs_i = 1'b1;
            #1;
            n_vec++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_err++; $display("FAIL b2b_ack[%0d]: got ack0=%b ack1=%b want 0 1", i, m0_ack_o, m1_ack_o); end
            n_vec++; if (mem_we_o !== (i < 4) || mem_addr_o !== 32'h200 + i || mem_data_o !== 32'hA0 + i) begin n_err++; $display("FAIL b2b_bus[%0d]: got we=%b a=%h d=%h", i, mem_we_o, mem_addr_o, mem_data_o); end
            n_vec++; if (m1_data_o !== 32'hDEAD_BEEF || m0_data_o !== 32'h0) begin n_err++; $display("FAIL b2b_rdata[%0d]: got d1=%h d0=%h want deadbeef 0", i, m1_data_o, m0_data_o); end
            tick();
            n_vec++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL b2b_hold[%0d]: got %0d want 2", i, arb_state); end
        end
        m1_cs_i = 1'b0; m1_we_i = 1'b0; mem_ack_i = 1'b0;
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL b2b_m0_next: got %0d want 1", arb_state); end
        m0_cs_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'h1234_5678;
        #1;
        n_vec++; if (m0_ack_o !== 1'b1 || m0_data_o !== 32'h1234_5678) begin n_err++; $display("FAIL last_ack_routed: got ack=%b d=%h want 1 12345678", m0_ack_o, m0_data_o); end
        tick();
        n_vec++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL last_ack_release: got %0d want 0", arb_state); end
        clear_inputs();
    endtask

    task automatic test_spurious_ack;
        mem_ack_i = 1'b1; mem_data_i = 32'h55;
        #1;
        n_vec++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_data_o !== '0 || m1_data_o !== '0) begin n_err++; $display("FAIL spurious_ack: got ack=%b%b d0=%h d1=%h want 00 0 0", m0_ack_o, m1_ack_o, m0_data_o, m1_data_o); end
        tick();
        n_vec++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL spurious_state: got %0d want 0", arb_state); end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_cs_i = 1'b1; mem_ack_i = 1'b1;
        tick();
        tick();
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL midrst_own: got %0d want 1", arb_state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (arb_state !== 2'd0 || mem_cs_o !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got state=%0d cs=%b want 0 0", arb_state, mem_cs_o); end
        m1_cs_i = 1'b1;
        tick();
        n_vec++; if (arb_state !== 2'd1) begin n_err++; $display("FAIL midrst_tie: got %0d want 1", arb_state); end
        clear_inputs();
        tick();
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf;
        do_reset();
        m0_cs_i = 1'b1;
        tick();
        m1_cs_i = 1'b1;
        repeat (4) tick();
        m0_cs_i = 1'b0;
        tick();
        n_vec++; if (arb_state !== 2'd2) begin n_err++; $display("FAIL perf_handoff: got %0d want 2", arb_state); end
        m1_cs_i = 1'b0;
        tick();
        n_vec++; if (perf_wait1_o !== 32'd5) begin n_err++; $display("FAIL perf_wait1: got %0d want 5", perf_wait1_o); end
        n_vec++; if (perf_wait0_o !== 32'd0) begin n_err++; $display("FAIL perf_wait0: got %0d want 0", perf_wait0_o); end
        n_vec++; if (perf_grant0_o !== 32'd1 || perf_grant1_o !== 32'd1) begin n_err++; $display("FAIL perf_grants: got %0d %0d want 1 1", perf_grant0_o, perf_grant1_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide memory port between two cache control units: port 0 is the instruction cache, port 1 is the data cache.
- Each requester uses the cache-miss memory protocol (cs/we/addr/data_o/data_i/ack). A requester holds cs high for the whole write-back plus refill sequence of a line.
- The arbiter grants ownership per whole transaction, not per word. A dirty write-back and its refill are never interleaved with the other requester.
- Round-robin between the two ports; sits between the two cache control units and the memory model or bus bridge.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- m0_cs_i  input  1  port 0 request/chip-select
- m0_we_i  input  1  port 0 write enable
- m0_addr_i  input  ADDR_WIDTH  port 0 word address
- m0_data_i  input  DATA_WIDTH  port 0 write data
- m0_data_o  output  DATA_WIDTH  port 0 read data
- m0_ack_o  output  1  port 0 acknowledge
- m1_cs_i, m1_we_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as port 0, for port 1
- mem_cs_o  output  1  memory chip-select
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_data_o  output  DATA_WIDTH  memory write data
- mem_data_i  input  DATA_WIDTH  memory read data
- mem_ack_i  input  1  memory acknowledge
- arb_state  output  2  debug: current FSM state

Behaviour:
- FSM states: S_IDLE=0, S_OWN0=1, S_OWN1=2. Encoding 3 is unreachable; if entered, return to S_IDLE next cycle.
- Priority pointer `last` (1 bit) names the most recently granted port.
- Reset: state=S_IDLE, last=1 (so port 0 wins the first tie). All mem_* outputs, mN_ack_o and mN_data_o are 0 while in S_IDLE.
- S_IDLE, at each clk edge:
  - only m0_cs_i=1 -> S_OWN0, last<=0
  - only m1_cs_i=1 -> S_OWN1, last<=1
  - both high -> grant the port != last
  - neither -> stay in S_IDLE
  - Arbitration costs exactly one cycle; nothing reaches memory in S_IDLE.
- S_OWNn:
  - mem_cs_o/we_o/addr_o/data_o = mn_* inputs, combinationally.
  - mn_ack_o = mem_ack_i; mn_data_o = mem_data_i.
  - The non-owner sees ack=0 and data=0, and its request is held pending (its cs stays high).
- Release: at the edge where the owner's cs_i=0, re-arbitrate in the same edge using the S_IDLE rules with the updated `last`. This lets the waiting port go next with no extra bubble, and the owner cannot immediately reclaim while the other port waits.
- Ownership never changes while the owner's cs_i=1, whatever the other port does.
- Owner deasserts cs in the same cycle mem_ack_i=1: that ack is still routed to the owner. The release takes effect at the following edge.
- mem_ack_i=1 in S_IDLE is ignored and not forwarded.
- The arbiter does not inspect we or addr; write-back to refill transitions (we 1->0 with cs held) stay within one ownership.
- rst=1 mid-transaction: next edge forces S_IDLE, last=1, outputs to 0. The in-flight word is dropped, and requesters are reset by the same rst.
- arb_state = state.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_grant0_o, perf_grant1_o (CNT_WIDTH): number of ownership grants per port.
  - perf_wait0_o, perf_wait1_o (CNT_WIDTH): cycles port n had cs_i=1 while not owner.
- Counters reset to 0 on rst, wrap modulo 2^CNT_WIDTH, and update at the same edge as the FSM.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset then m0_cs_i=1, addr 0x100, memory acks each cycle:
  - arb_state goes 0->1 one cycle after the request.
  - mem_addr_o=0x100, m0_ack_o follows mem_ack_i, m1_ack_o=0.
- m0 and m1 both raise cs in the same cycle after reset:
  - port 0 granted first.
  - When m0 drops cs, S_OWN1 at the next edge with no S_IDLE cycle.
  - A following simultaneous pair is granted to port 0 (alternation).
- m1 owns and performs 4 write words (we=1) then 4 read words (we=0) with cs held; m0 requests mid-way:
  - all 8 acks go to m1.
  - m0 granted only after m1 cs drops.
  - mem_data_i 0xDEADBEEF seen only on m1_data_o.
- Spurious mem_ack_i=1 while in S_IDLE -> m0_ack_o=m1_ack_o=0, state remains 0.
- rst asserted during S_OWN0 at word 2:
  - next cycle arb_state=0 and mem_cs_o=0.
  - Post-reset simultaneous request grants port 0.
- With MEM_ARB_PERF_EN: m1 waits 5 cycles behind m0, then both are granted once -> perf_wait1_o=5, perf_grant0_o=1, perf_grant1_o=1, perf_wait0_o=0.
